inst_fetch_buf: RTL and testbench

Instruction fetch front-end that produces the {pc, inst} pairs consumed by the decode stage. It owns the PC register and issues sequential word fetches to the instruction memory, one request outstanding at a time. Returned words go into a small prefetch FIFO, which the decode stage drains through a valid/ready handshake. A redirect input (branch/jump target from later stages) flushes the FIFO and restarts fetch at a new address.

---
 rtl/inst_fetch_buf.sv | 174 +++++++++++++++++
 tb/tb_inst_fetch_buf.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_buf.sv
// inst_fetch_buf - instruction fetch front-end with prefetch FIFO.
//
// Owns the PC and issues sequential word fetches to instruction memory,
// with one request outstanding at a time. Returned words are queued as
// {pc, inst} pairs in a DEPTH-entry FIFO. The decode stage drains the FIFO
// through a valid/ready handshake. A redirect flushes the FIFO and restarts
// fetch at redirect_pc_i. If a redirect arrives while a request is in flight,
// that request is still completed, but its data is dropped.
//
// Optional macro: IFB_BYPASS_EN. When it is defined and the FIFO is empty,
// an acked word is presented on pc_o/inst_o in the same cycle as the ack.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   redirect_i        flush and restart fetch at redirect_pc_i
//   redirect_pc_i     new fetch address (word aligned)
//   mem_req_o         fetch request, held until mem_ack_i
//   mem_addr_o        fetch address, stable while mem_req_o=1
//   mem_ack_i         memory returns mem_rdata_i for the current request
//   mem_rdata_i       instruction word
//   valid_o/ready_i   decode handshake for the head entry
//   pc_o, inst_o      head entry (hold last value when valid_o=0)
//   count_o           FIFO occupancy

module inst_fetch_buf #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  output logic                     mem_req_o,
  output logic [31:0]              mem_addr_o,
  input  logic                     mem_ack_i,
  input  logic [31:0]              mem_rdata_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [31:0]              pc_o,
  output logic [31:0]              inst_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] CNT_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STALE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [31:0]   r_pc;
  logic [31:0]   r_stale_addr;
  logic [31:0]   r_hold_pc;
  logic [31:0]   r_hold_inst;
  logic [31:0]   r_fifo_pc   [DEPTH];
  logic [31:0]   r_fifo_inst [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_after_pop;
  logic [AW:0]   w_count_next;
  logic          w_nonempty;
  logic          w_ack_live;
  logic          w_bypass;
  logic          w_bypass_take;
  logic          w_pop;
  logic          w_push;

  assign w_nonempty = (r_count != '0);
  // Only an ack for a request whose data we intend to keep counts as data.
  // An ack seen in IDLE (e.g. just after reset) is ignored.
  assign w_ack_live = (r_state == WAIT) && mem_ack_i;

`ifdef IFB_BYPASS_EN
  assign w_bypass = !w_nonempty && w_ack_live && !redirect_i;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed word consumed by decode is never written into the FIFO.
  assign w_bypass_take     = w_bypass && ready_i;
  // A redirect voids any pop or push in the same cycle.
  assign w_pop             = w_nonempty && ready_i && !redirect_i;
  assign w_push            = w_ack_live && !redirect_i && !w_bypass_take;
  assign w_count_after_pop = r_count - (AW+1)'(w_pop);
  assign w_count_next      = w_count_after_pop + (AW+1)'(w_push);

  assign mem_req_o  = (r_state != IDLE);
  // In STALE, r_pc already holds the redirect target. The old address stays
  // on the bus until the abandoned request is acked.
  assign mem_addr_o = (r_state == STALE) ? r_stale_addr : r_pc;
  assign valid_o    = w_nonempty || w_bypass;
  assign pc_o       = w_bypass   ? r_pc :
                      w_nonempty ? r_fifo_pc[r_rd_ptr] : r_hold_pc;
  assign inst_o     = w_bypass   ? mem_rdata_i :
                      w_nonempty ? r_fifo_inst[r_rd_ptr] : r_hold_inst;
  assign count_o    = r_count;

  // Credit rule: a new request is issued only if the FIFO has room for its
  // data, counting this cycle's pop and push.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (!redirect_i && (w_count_after_pop < CNT_DEPTH))
          w_state_next = WAIT;
      end
      WAIT: begin
        if (redirect_i)
          w_state_next = mem_ack_i ? IDLE : STALE;
        else if (mem_ack_i)
          w_state_next = (w_count_next < CNT_DEPTH) ? WAIT : IDLE;
      end
      STALE: begin
        if (mem_ack_i)
          w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_fifo_pc[r_wr_ptr]   <= r_pc;
      r_fifo_inst[r_wr_ptr] <= mem_rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_stale_addr <= RESET_PC;
      r_hold_pc    <= '0;
      r_hold_inst  <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == WAIT && redirect_i && !mem_ack_i)
        r_stale_addr <= r_pc;
      if (redirect_i) begin
        r_pc        <= redirect_pc_i;
        r_hold_pc   <= '0;
        r_hold_inst <= '0;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
      end else begin
        if (w_ack_live)
          r_pc <= r_pc + 32'd4;
        if (w_push)
          r_wr_ptr <= r_wr_ptr + 1'b1;
        // The hold registers track the most recently consumed entry. They are
        // shown once the FIFO runs dry.
        if (w_pop) begin
          r_rd_ptr    <= r_rd_ptr + 1'b1;
          r_hold_pc   <= r_fifo_pc[r_rd_ptr];
          r_hold_inst <= r_fifo_inst[r_rd_ptr];
        end else if (w_bypass_take) begin
          r_hold_pc   <= r_pc;
          r_hold_inst <= mem_rdata_i;
        end
        r_count <= w_count_next;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Self-checking bench for inst_fetch_buf: cycle-exact vector table plus
// hand-written sequences for FIFO fill/credit and PC wrap-around.
module tb_inst_fetch_buf;

`ifdef IFB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [31:0] W0  = 32'h3401_0011;
  localparam logic [31:0] W1  = 32'h3402_0022;
  localparam logic [31:0] W2  = 32'h3403_0033;
  localparam logic [31:0] W3  = 32'h3404_0044;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;
  localparam logic [31:0] KEY = 32'h5A00_0000;

  logic        clk;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        ready_i;

  logic        mem_req_o,  mem_req2;
  logic [31:0] mem_addr_o, mem_addr2;
  logic        valid_o,    valid2;
  logic [31:0] pc_o,       pc2;
  logic [31:0] inst_o,     inst2;
  logic [2:0]  count_o,    count2;

  inst_fetch_buf #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .valid_o(valid_o), .ready_i(ready_i),
    .pc_o(pc_o), .inst_o(inst_o), .count_o(count_o)
  );

  inst_fetch_buf #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .mem_req_o(mem_req2), .mem_addr_o(mem_addr2), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .valid_o(valid2), .ready_i(ready_i),
    .pc_o(pc2), .inst_o(inst2), .count_o(count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_err    = 0;
  logic prev_req, prev_ack;

  function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rp,
                              input logic a, input logic [31:0] d, input logic y,
                              input logic q, input logic [31:0] ad, input logic v,
                              input logic [31:0] p, input logic [31:0] i, input logic [2:0] c);
    vec_t t;
    t.rst = r; t.redir = rd; t.rpc = rp; t.ack = a; t.rdata = d; t.rdy = y;
    t.req = q; t.addr = ad; t.vld = v; t.pc = p; t.inst = i; t.cnt = c;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Memory model for hand sequences: ack each request one cycle after it is
  // first seen; data is derived from the address.
  task automatic auto_step(input logic rdy);
    rst           = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    ready_i       = rdy;
    mem_ack_i     = mem_req_o && prev_req && !prev_ack;
    mem_rdata_i   = mem_addr_o ^ KEY;
    @(negedge clk);
    prev_req = mem_req_o;
    prev_ack = mem_ack_i;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0; ready_i = 1'b0;
    adv();
    adv();
    prev_req = 1'b0;
    prev_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_pc [3];
    int          k;
    logic        exp_v;

    // Sequence A: streaming fetch with decode always ready.
    vq.push_back(mk(0,0,0, 0,0,   1, 0,32'h0, 0,          0,           0,           0));
    vq.push_back(mk(0,0,0, 0,0,   1, 1,32'h0, 0,          0,           0,           0));
    vq.push_back(mk(0,0,0, 1,W0,  1, 1,32'h0, BYP,        0,           BYP ? W0:0,  0));
    vq.push_back(mk(0,0,0, 0,0,   1, 1,32'h4, !BYP,       0,           W0,          BYP ? 0:1));
    vq.push_back(mk(0,0,0, 1,W1,  1, 1,32'h4, BYP,        BYP ? 4:0,   BYP ? W1:W0, 0));
    vq.push_back(mk(0,0,0, 0,0,   1, 1,32'h8, !BYP,       4,           W1,          BYP ? 0:1));
    vq.push_back(mk(0,0,0, 1,W2,  1, 1,32'h8, BYP,        BYP ? 8:4,   BYP ? W2:W1, 0));
    vq.push_back(mk(0,0,0, 0,0,   1, 1,32'hC, !BYP,       8,           W2,          BYP ? 0:1));
    vq.push_back(mk(1,0,0, 0,0,   0, 1,32'hC, 0,          8,           W2,          0));
    // Sequence B: redirect coincides with ack and a pop.
    vq.push_back(mk(0,0,0, 0,0,   0, 0,32'h0, 0,          0,           0,           0));
    vq.push_back(mk(0,0,0, 0,0,   0, 1,32'h0, 0,          0,           0,           0));
    vq.push_back(mk(0,0,0, 1,W0,  0, 1,32'h0, BYP,        0,           BYP ? W0:0,  0));
    vq.push_back(mk(0,0,0, 0,0,   0, 1,32'h4, 1,          0,           W0,          1));
    vq.push_back(mk(0,1,32'h200, 1,W1, 1, 1,32'h4, 1,     0,           W0,          1));
    vq.push_back(mk(0,0,0, 0,0,   0, 0,32'h200, 0,        0,           0,           0));
    vq.push_back(mk(0,0,0, 0,0,   0, 1,32'h200, 0,        0,           0,           0));
    vq.push_back(mk(0,0,0, 1,W2,  0, 1,32'h200, BYP,      BYP ? 32'h200:0, BYP ? W2:0, 0));
    vq.push_back(mk(0,0,0, 0,0,   0, 1,32'h204, 1,        32'h200,     W2,          1));
    vq.push_back(mk(1,0,0, 0,0,   0, 1,32'h204, 1,        32'h200,     W2,          1));
    // Sequence C: redirect while a request to 0x8 is outstanding; ack 3 cycles later.
    vq.push_back(mk(0,0,0, 0,0,   1, 0,32'h0, 0,          0,           0,           0));
    vq.push_back(mk(0,0,0, 0,0,   1, 1,32'h0, 0,          0,           0,           0));
    vq.push_back(mk(0,0,0, 1,W0,  1, 1,32'h0, BYP,        0,           BYP ? W0:0,  0));
    vq.push_back(mk(0,0,0, 0,0,   1, 1,32'h4, !BYP,       0,           W0,          BYP ? 0:1));
    vq.push_back(mk(0,0,0, 1,W1,  1, 1,32'h4, BYP,        BYP ? 4:0,   BYP ? W1:W0, 0));
    vq.push_back(mk(0,1,32'h100, 0,0, 1, 1,32'h8, !BYP,   4,           W1,          BYP ? 0:1));
    vq.push_back(mk(0,0,0, 0,0,   1, 1,32'h8, 0,          0,           0,           0));
    vq.push_back(mk(0,0,0, 0,0,   1, 1,32'h8, 0,          0,           0,           0));
    vq.push_back(mk(0,0,0, 1,BAD, 1, 1,32'h8, 0,          0,           0,           0));
    vq.push_back(mk(0,0,0, 0,0,   1, 0,32'h100, 0,        0,           0,           0));
    vq.push_back(mk(0,0,0, 0,0,   1, 1,32'h100, 0,        0,           0,           0));
    vq.push_back(mk(0,0,0, 1,W3,  1, 1,32'h100, BYP,      BYP ? 32'h100:0, BYP ? W3:0, 0));
    vq.push_back(mk(0,0,0, 0,0,   1, 1,32'h104, !BYP,     32'h100,     W3,          BYP ? 0:1));
    // Sequence D: reset while in WAIT; a stray ack right after reset is ignored.
    vq.push_back(mk(1,0,0, 0,0,   1, 1,32'h104, 0,        32'h100,     W3,          0));
    vq.push_back(mk(0,0,0, 1,BAD, 1, 0,32'h0, 0,          0,           0,           0));
    vq.push_back(mk(0,0,0, 0,0,   1, 1,32'h0, 0,          0,           0,           0));
    vq.push_back(mk(0,0,0, 1,W0,  1, 1,32'h0, BYP,        0,           BYP ? W0:0,  0));
    vq.push_back(mk(0,0,0, 0,0,   1, 1,32'h4, !BYP,       0,           W0,          BYP ? 0:1));
    // Sequence E: a second redirect in STALE only moves the restart address.
    vq.push_back(mk(0,1,32'h300, 0,0, 1, 1,32'h4, 0,      0,           W0,          0));
    vq.push_back(mk(0,1,32'h400, 0,0, 1, 1,32'h4, 0,      0,           0,           0));
    vq.push_back(mk(0,0,0, 1,BAD, 1, 1,32'h4, 0,          0,           0,           0));
    vq.push_back(mk(0,0,0, 0,0,   1, 0,32'h400, 0,        0,           0,           0));
    vq.push_back(mk(0,0,0, 0,0,   1, 1,32'h400, 0,        0,           0,           0));

    do_reset();
    for (int i = 0; i < vq.size(); i++) begin
      rst           = vq[i].rst;
      redirect_i    = vq[i].redir;
      redirect_pc_i = vq[i].rpc;
      mem_ack_i     = vq[i].ack;
      mem_rdata_i   = vq[i].rdata;
      ready_i       = vq[i].rdy;
      @(negedge clk);
      $display("row %0d: req=%b addr=%08h vld=%b pc=%08h inst=%08h cnt=%0d",
               i, mem_req_o, mem_addr_o, valid_o, pc_o, inst_o, count_o);
      chk($sformatf("row%0d mem_req", i),  32'(mem_req_o), 32'(vq[i].req));
      chk($sformatf("row%0d mem_addr", i), mem_addr_o,      vq[i].addr);
      chk($sformatf("row%0d valid", i),    32'(valid_o),   32'(vq[i].vld));
      chk($sformatf("row%0d pc", i),       pc_o,            vq[i].pc);
      chk($sformatf("row%0d inst", i),     inst_o,          vq[i].inst);
      chk($sformatf("row%0d count", i),    32'(count_o),   32'(vq[i].cnt));
      adv();
    end

    // Decode stalled: exactly four pushes, then fetch stops on credit.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      auto_step(1'b0);
      adv();
    end
    auto_step(1'b0);
    $display("full: cnt=%0d req=%b pc=%08h", count_o, mem_req_o, pc_o);
    chk("full count", 32'(count_o), 32'd4);
    chk("full req",   32'(mem_req_o), 32'd0);
    chk("full valid", 32'(valid_o), 32'd1);
    chk("full pc",    pc_o, 32'h0);
    chk("full inst",  inst_o, 32'h0 ^ KEY);
    adv();
    auto_step(1'b1);
    $display("pop while full: vld=%b req=%b", valid_o, mem_req_o);
    chk("popfull valid", 32'(valid_o), 32'd1);
    chk("popfull req",   32'(mem_req_o), 32'd0);
    adv();
    auto_step(1'b0);
    $display("after pop: req=%b addr=%08h cnt=%0d pc=%08h", mem_req_o, mem_addr_o, count_o, pc_o);
    chk("credit req",   32'(mem_req_o), 32'd1);
    chk("credit addr",  mem_addr_o, 32'h10);
    chk("credit count", 32'(count_o), 32'd3);
    chk("credit pc",    pc_o, 32'h4);
    adv();
    for (int j = 0; j < 4; j++) begin
      auto_step(1'b1);
      $display("drain %0d: pc=%08h inst=%08h", j, pc_o, inst_o);
      chk($sformatf("drain%0d pc", j),   pc_o,   32'(4 + 4*j));
      chk($sformatf("drain%0d inst", j), inst_o, 32'(4 + 4*j) ^ KEY);
      adv();
    end

    // PC wrap-around from RESET_PC = 0xFFFF_FFF8.
    exp_pc[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000;
    k = 0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      auto_step(1'b1);
      exp_v = BYP ? (c == 2 || c == 4 || c == 6) : (c == 3 || c == 5 || c == 7);
      $display("wrap c%0d: vld=%b pc=%08h addr=%08h", c, valid2, pc2, mem_addr2);
      chk($sformatf("wrap c%0d valid", c), 32'(valid2), 32'(exp_v));
      if (exp_v && k < 3) begin
        chk($sformatf("wrap c%0d pc", c), pc2, exp_pc[k]);
        k++;
      end
      if (c == 5)
        chk("wrap addr", mem_addr2, 32'h0);
      adv();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
